// File: rtl/stream_mux_dmux_router_pkg.sv
// Shared constants and helpers for the stream mux/dmux router.
// Holds the mode encodings and the index-width helper functions.
package mux_dmux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_dmux_router_if.sv
// Valid/ready bus bundle for the router: N_IN sources, N_OUT sinks.
// master = traffic side (drives in_*, out_ready); slave = router.
interface stream_mux_dmux_router_if #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DW     = 8,
  parameter int DEST_W = 2
);

  logic [N_IN-1:0]        in_valid;
  logic [N_IN*DW-1:0]     in_data;
  logic [N_IN*DEST_W-1:0] in_dest;
  logic [N_IN-1:0]        in_ready;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT*DW-1:0]    out_data;
  logic [N_OUT-1:0]       out_ready;

  modport master (
    output in_valid, in_data, in_dest,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dest,
    input  out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_mux_dmux_router_rr_arbiter.sv
// Combinational round-robin arbiter; search starts after i_last_grant.
// Ports: i_req, i_last_grant, i_enable -> o_grant, o_grant_valid.
module rr_arbiter
  import mux_dmux_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last_grant,
  input  logic         i_enable,
  output logic [W-1:0] o_grant,
  output logic         o_grant_valid
);

  always_comb begin
    int w_idx;
    w_idx         = 0;
    o_grant       = '0;
    o_grant_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_last_grant) + k) % N;
      if (i_enable && !o_grant_valid && i_req[w_idx]) begin
        o_grant       = W'(w_idx);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_dmux_router.sv
// Registered N_IN:1 mux -> one holding stage -> 1:N_OUT dmux.
// Ports: clk, rst, mode, in_sel, bus (slave), xfer/drop counts, status_led.
module stream_mux_dmux_router
  import mux_dmux_pkg::*;
#(
  parameter  int N_IN   = 4,
  parameter  int N_OUT  = 4,
  parameter  int DW     = 8,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = idx_w(N_IN),
  localparam int DEST_W = idx_w(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] in_sel,
  stream_mux_dmux_router_if.slave bus,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [1:0]       status_led
);

  logic              r_hold_valid;
  logic [DW-1:0]     r_hold_data;
  logic [DEST_W-1:0] r_hold_dest;
  logic [SEL_W-1:0]  r_last_grant;
  logic [CNT_W-1:0]  r_xfer;
  logic [CNT_W-1:0]  r_drop;

  logic [N_OUT-1:0]  w_out_valid;
  logic              w_drain;
  logic              w_can_accept;
  logic              w_sel_valid;
  logic [SEL_W-1:0]  w_rr_grant;
  logic              w_rr_valid;
  logic [SEL_W-1:0]  w_grant;
  logic              w_grant_valid;
  logic [N_IN-1:0]   w_in_ready;
  logic [DW-1:0]     w_in_data;
  logic [DEST_W-1:0] w_in_dest;
  logic              w_acc;
  logic              w_dest_ok;

  rr_arbiter #(.N(N_IN)) u_arb (
    .i_req        (bus.in_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (mode == MODE_RR),
    .o_grant      (w_rr_grant),
    .o_grant_valid(w_rr_valid)
  );

  always_comb begin
    w_out_valid = '0;
    for (int d = 0; d < N_OUT; d++)
      w_out_valid[d] = r_hold_valid &&
        (r_hold_dest == DEST_W'(d));
  end

  assign w_drain      = |(w_out_valid & bus.out_ready);
  assign w_can_accept = !r_hold_valid || w_drain;

  // Out-of-range in_sel simply never matches
  always_comb begin
    w_sel_valid = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (in_sel == SEL_W'(i) && bus.in_valid[i])
        w_sel_valid = 1'b1;
  end

  assign w_grant = (mode == MODE_RR) ? w_rr_grant : in_sel;
  assign w_grant_valid =
    (mode == MODE_RR) ? w_rr_valid : w_sel_valid;

  always_comb begin
    w_in_ready = '0;
    w_in_data  = '0;
    w_in_dest  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_in_data = bus.in_data[i*DW +: DW];
        w_in_dest = bus.in_dest[i*DEST_W +: DEST_W];
        w_in_ready[i] = w_grant_valid && w_can_accept && !rst;
      end
    end
  end

  assign w_acc     = |(w_in_ready & bus.in_valid);
  assign w_dest_ok = int'(w_in_dest) < N_OUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_dest  <= '0;
      r_last_grant <= SEL_W'(N_IN - 1);
      r_xfer       <= '0;
      r_drop       <= '0;
    end else begin
      // A legal load wins over a drain: no bubble
      if (w_acc && w_dest_ok) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= w_in_data;
        r_hold_dest  <= w_in_dest;
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end
      if (w_acc && mode == MODE_RR)
        r_last_grant <= w_grant;
      if (w_drain && r_xfer != '1)
        r_xfer <= r_xfer + 1'b1;
      if (w_acc && !w_dest_ok && r_drop != '1)
        r_drop <= r_drop + 1'b1;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int d = 0; d < N_OUT; d++)
      if (w_out_valid[d])
        bus.out_data[d*DW +: DW] = r_hold_data;
  end

  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign xfer_count    = r_xfer;
  assign drop_count    = r_drop;
  assign status_led    = {r_hold_valid && !w_drain,
                          |w_out_valid};

endmodule

// File: doc/stream_mux_dmux_router.md
Name: stream_mux_dmux_router

Overview:
- Parametrised, registered N_IN:1 multiplexer feeding a 1:N_OUT demultiplexer through a single holding stage.
- All inputs and outputs use valid/ready handshakes.
- Input selection is either static (select port) or round-robin, chosen at run time.
- Sits between channel sources and sinks as the next-generation replacement for the combinational 4:1 mux / 1:4 dmux pair. It adds flow control, throughput counters and stall status.

Parameters:
- N_IN, 4, number of input channels (>=2)
- N_OUT, 4, number of output channels (>=2)
- DW, 8, data width per channel
- CNT_W, 16, width of transfer and drop counters
- Derived (localparam): SEL_W = max(1, clog2(N_IN)); DEST_W = max(1, clog2(N_OUT))

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = static select, 1 = round-robin
- in_sel  in  SEL_W  input channel chosen in mode 0
- in_valid  in  N_IN  per-input valid
- in_data  in  N_IN*DW  packed input data; channel i at [i*DW +: DW]
- in_dest  in  N_IN*DEST_W  packed destination index per input
- in_ready  out  N_IN  per-input ready
- out_valid  out  N_OUT  per-output valid
- out_data  out  N_OUT*DW  packed output data
- out_ready  in  N_OUT  per-output ready
- xfer_count  out  CNT_W  completed output handshakes, saturating
- drop_count  out  CNT_W  accepted words with illegal destination, saturating
- status_led  out  2  [0] = |out_valid; [1] = stall

Behaviour:
- Reset (rst high at a clk edge), all outputs registered or derived:
  - hold_valid = 0; out_valid = 0; out_data = 0; in_ready = 0
  - xfer_count = 0; drop_count = 0; status_led = 0
  - last_grant = N_IN-1, so the first round-robin grant goes to channel 0
  - Reset mid-transfer discards the held word; it is not counted.
- Holding stage:
  - One entry: hold_valid, hold_data, hold_dest.
  - can_accept = !hold_valid || out_ready[hold_dest]. This allows a back-to-back pass-through of one word per cycle.
- Grant, mode 0:
  - grant = in_sel when in_sel < N_IN and in_valid[in_sel] = 1; otherwise no grant.
- Grant, mode 1:
  - First valid channel searched cyclically from last_grant+1.
  - last_grant updates only on an accepted input handshake.
- Mode or in_sel changes take effect in the same cycle's arbitration; the held word is unaffected.
- in_ready[i] = grant_valid && (grant == i) && can_accept. At most one bit is set; it is combinational from in_valid, mode, in_sel and state.
- Input handshake (in_valid[i] && in_ready[i]):
  - If in_dest < N_OUT: load the holding stage next cycle (latency 1 cycle input-to-output).
  - If in_dest >= N_OUT (only possible when N_OUT is not a power of 2): the word is consumed, not stored, and drop_count increments. The holding stage is left unchanged unless it drains that cycle, in which case hold_valid clears.
- Outputs:
  - out_valid[d] = hold_valid && (hold_dest == d).
  - out_data slice d = hold_data when out_valid[d] = 1, else 0.
  - Non-selected outputs are always 0, matching the existing dmux convention.
- Output handshake on hold_dest:
  - hold_valid clears unless a new word loads in the same cycle.
  - xfer_count increments.
- Simultaneous drain and load in one cycle: the new word replaces the held word, with no bubble.
- Counters saturate at all-ones and never wrap.
- status_led[1] (stall) = hold_valid && !out_ready[hold_dest].
- Held data is stable while out_valid is high and out_ready is low.

Decomposition:
- Shared package mux_dmux_pkg holds:
  - MODE_SEL = 1'b0 and MODE_RR = 1'b1
  - a clog2 constant function used for SEL_W and DEST_W
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req[N], last_grant, enable.
  - Outputs: grant index, grant_valid.
  - Purely combinational.
  - last_grant is stored in the parent.
- The mode-0 path and the holding stage stay in the top.

Test Plan:
- Mode 0, in_sel=2, in_valid=4'b0100, in_data ch2=8'hA5, in_dest ch2=3, out_ready=4'hF -> next cycle out_valid=4'b1000, out_data[31:24]=A5, other slices 0; xfer_count=1.
- Mode 1, all four inputs valid continuously, each with a distinct dest, out_ready=all 1 -> grants 0,1,2,3,0 on consecutive cycles; one word out per cycle; xfer_count=5 after 5 outputs.
- Held word with dest=1, out_ready[1]=0 for 3 cycles -> out_data stable, status_led=2'b11, in_ready=0. Raise out_ready[1] -> same cycle in_ready to the granted channel, new word loaded with no bubble.
- N_OUT=3, input with dest=3 -> in_ready=1, drop_count=1, no out_valid, xfer_count unchanged.
- rst asserted while a word is held and stalled -> next cycle out_valid=0, counters 0. The first round-robin grant after reset is channel 0.
- CNT_W=4, 20 transfers -> xfer_count holds 4'hF and does not wrap.
